// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - RV32I decode/issue stage feeding the ALU control interface through a 2-entry skid slot
module alu_ctrl_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] Instr_i,
   input  logic [XLEN-1:0] PC_i,
   input  logic            Valid_i,
   output logic            Ready_o,
   input  logic            Flush_i,
   input  logic            ExReady_i,
   output logic            ExValid_o,
   output logic [XLEN-1:0] ExPC_o,
   output logic [3:0]      ALUCtrl_o,
   output logic [2:0]      Flagsel_o,
   output logic [1:0]      ASel_o,
   output logic            BSel_o,
   output logic [XLEN-1:0] Imm_o,
   output logic [4:0]      Rs1_o,
   output logic [4:0]      Rs2_o,
   output logic [4:0]      Rd_o,
   output logic            RegWrite_o,
   output logic [1:0]      WbSel_o,
   output logic            MemRead_o,
   output logic            MemWrite_o,
   output logic            Branch_o,
   output logic            Jump_o,
   output logic            Illegal_o
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_ctrl;
      logic [2:0]      flagsel;
      logic [1:0]      asel;
      logic            bsel;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_write;
      logic [1:0]      wb_sel;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            illegal;
   } slot_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

   state_t state, state_nxt;
   slot_t  dec, main_q, skid_q;
   logic   ld_main_in, ld_main_skid, ld_skid;
   logic   dec_legal;
   logic   accept, issue;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = Instr_i[6:0];
   assign funct3 = Instr_i[14:12];
   assign funct7 = Instr_i[31:25];

   // R-type / I-type arithmetic funct3 to ALU control; alt selects sub or sra
   function automatic logic [3:0] op_ctrl(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  op_ctrl = alt ? 4'b0001 : 4'b0000;
         3'b001:  op_ctrl = 4'b0010;
         3'b010:  op_ctrl = 4'b0001;
         3'b011:  op_ctrl = 4'b0001;
         3'b100:  op_ctrl = 4'b0011;
         3'b101:  op_ctrl = alt ? 4'b0101 : 4'b0100;
         3'b110:  op_ctrl = 4'b0110;
         default: op_ctrl = 4'b0111;
      endcase
   endfunction

   // Decode the incoming instruction into a slot image
   always_comb begin
      dec           = '0;
      dec_legal     = 1'b1;
      dec.pc        = PC_i;
      dec.rs1       = Instr_i[19:15];
      dec.rs2       = Instr_i[24:20];
      dec.rd        = Instr_i[11:7];
      case (opcode)
         7'b0110011: begin
            dec_legal     = (funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            dec.alu_ctrl  = op_ctrl(funct3, funct7[5]);
            dec.reg_write = 1'b1;
         end
         7'b0010011: begin
            dec.bsel      = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:20]};
            dec.alu_ctrl  = op_ctrl(funct3, (funct3 == 3'b101) && funct7[5]);
            if (funct3 == 3'b001) begin
               dec.imm   = {{(XLEN-5){1'b0}}, Instr_i[24:20]};
               dec_legal = (funct7 == 7'b0000000);
            end else if (funct3 == 3'b101) begin
               dec.imm   = {{(XLEN-5){1'b0}}, Instr_i[24:20]};
               dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
         end
         7'b0110111: begin
            dec.alu_ctrl  = 4'b1000;
            dec.bsel      = 1'b1;
            dec.imm       = {12'b0, Instr_i[31:12]};
            dec.reg_write = 1'b1;
         end
         7'b0010111: begin
            dec.asel      = 2'b01;
            dec.bsel      = 1'b1;
            dec.imm       = {Instr_i[31:12], 12'b0};
            dec.reg_write = 1'b1;
         end
         7'b0000011: begin
            dec.bsel      = 1'b1;
            dec.imm       = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:20]};
            dec.mem_read  = 1'b1;
            dec.wb_sel    = 2'b10;
            dec.reg_write = 1'b1;
            dec_legal     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         end
         7'b0100011: begin
            dec.bsel      = 1'b1;
            dec.imm       = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
            dec.mem_write = 1'b1;
            dec_legal     = funct3 inside {3'b000, 3'b001, 3'b010};
         end
         7'b1100011: begin
            dec.alu_ctrl  = 4'b0001;
            dec.flagsel   = funct3;
            dec.branch    = 1'b1;
            dec.imm       = {{(XLEN-12){Instr_i[31]}}, Instr_i[7], Instr_i[30:25], Instr_i[11:8], 1'b0};
            dec_legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         7'b1101111: begin
            dec.asel      = 2'b01;
            dec.bsel      = 1'b1;
            dec.imm       = {{(XLEN-20){Instr_i[31]}}, Instr_i[19:12], Instr_i[20], Instr_i[30:21], 1'b0};
            dec.jump      = 1'b1;
            dec.wb_sel    = 2'b11;
            dec.reg_write = 1'b1;
         end
         7'b1100111: begin
            dec.bsel      = 1'b1;
            dec.imm       = {{(XLEN-12){Instr_i[31]}}, Instr_i[31:20]};
            dec.jump      = 1'b1;
            dec.wb_sel    = 2'b11;
            dec.reg_write = 1'b1;
            dec_legal     = (funct3 == 3'b000);
         end
         default: dec_legal = 1'b0;
      endcase
      if (opcode inside {7'b0110011, 7'b0010011}) begin
         if (funct3 == 3'b010) begin
            dec.flagsel = 3'b100;
            dec.wb_sel  = 2'b01;
         end else if (funct3 == 3'b011) begin
            dec.flagsel = 3'b110;
            dec.wb_sel  = 2'b01;
         end
      end
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
      if (!dec_legal) begin
         dec.alu_ctrl  = 4'b0000;
         dec.flagsel   = 3'b000;
         dec.asel      = 2'b00;
         dec.bsel      = 1'b0;
         dec.imm       = '0;
         dec.wb_sel    = 2'b00;
         dec.reg_write = 1'b0;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
         dec.illegal   = 1'b1;
      end
   end

   assign Ready_o   = (state != FULL) && !rst_i;
   assign ExValid_o = (state != EMPTY);
   assign accept    = Valid_i && Ready_o;
   assign issue     = ExValid_o && ExReady_i;

   // Slot occupancy state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next occupancy and which register loads from where; flush overrides all movement
   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt  = HALF;
               ld_main_in = 1'b1;
            end
         end
         HALF: begin
            if (accept && !issue) begin
               state_nxt = FULL;
               ld_skid   = 1'b1;
            end else if (accept && issue) begin
               ld_main_in = 1'b1;
            end else if (issue) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (issue) begin
               state_nxt    = HALF;
               ld_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (Flush_i) begin
         state_nxt    = EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   // Main and skid payload registers; main drives every EX output
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (ld_main_in) begin
            main_q <= dec;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid) begin
            skid_q <= dec;
         end
      end
   end

   assign ExPC_o     = main_q.pc;
   assign ALUCtrl_o  = main_q.alu_ctrl;
   assign Flagsel_o  = main_q.flagsel;
   assign ASel_o     = main_q.asel;
   assign BSel_o     = main_q.bsel;
   assign Imm_o      = main_q.imm;
   assign Rs1_o      = main_q.rs1;
   assign Rs2_o      = main_q.rs2;
   assign Rd_o       = main_q.rd;
   assign RegWrite_o = main_q.reg_write;
   assign WbSel_o    = main_q.wb_sel;
   assign MemRead_o  = main_q.mem_read;
   assign MemWrite_o = main_q.mem_write;
   assign Branch_o   = main_q.branch;
   assign Jump_o     = main_q.jump;
   assign Illegal_o  = main_q.illegal;

endmodule
